// File: rtl/trs_text_pixel_gen.sv
// Text-mode pixel generator for the TRS-80 style display.
// Each 6-pixel cell fetches a code from video RAM, then either drives the
// character-generator ROM (text) or decodes 2x3 block graphics. The result
// is shifted out MSB first. Cell k is fetched while cell k-1 is on screen.
// Pipeline per cell:
//   phase0: vram_addr issued, data valid during phase1
//   phase1: code captured, rom_ad issued, rom_ce pulsed
//   phase2: rom_oce pulsed
//   phase3 onward: rom_dout stable
//   phase5: next cell pattern loaded into the shifter
// Wide mode holds every pixel for two ticks. The phase counter therefore
// advances only on every second tick in that mode.
module trs_text_pixel_gen #(
    parameter int COLS   = 64,
    parameter int CELL_W = 6
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_pix_en,
    input  logic       i_line_start,
    input  logic [3:0] i_text_row,
    input  logic [3:0] i_char_row,
    input  logic       i_mode_wide,
    output logic [9:0] o_vram_addr,
    input  logic [7:0] i_vram_data,
    output logic [9:0] o_rom_ad,
    output logic       o_rom_ce,
    output logic       o_rom_oce,
    input  logic [4:0] i_rom_dout,
    output logic       o_pixel,
    output logic       o_de,
    output logic [1:0] o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PREFETCH = 2'd1,
        S_ACTIVE   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [2:0]  r_phase;
    logic        r_sub;
    logic        r_wide;
    logic [3:0]  r_text_row;
    logic [3:0]  r_char_row;
    logic [5:0]  r_col;
    logic [5:0]  r_cell;
    logic [7:0]  r_code;
    logic [5:0]  r_shift;
    logic        r_de;
    logic [9:0]  r_vram_addr;
    logic [9:0]  r_rom_ad;
    logic        r_rom_ce;
    logic        r_rom_oce;

    logic        w_start;
    logic        w_adv;
    logic        w_cell_end;
    logic        w_last_cell;
    logic        w_fetch;
    logic [2:0]  w_gfx_idx;
    logic [1:0]  w_gfx_pair;
    logic [5:0]  w_pattern;
    logic        w_de;

    assign w_start     = i_pix_en & i_line_start;
    assign w_adv       = i_pix_en & (r_state != S_IDLE) & (~r_wide | r_sub);
    assign w_cell_end  = w_adv & (r_phase == 3'(CELL_W - 1));
    assign w_last_cell = (r_cell == (r_wide ? 6'(COLS / 2 - 1) : 6'(COLS - 1)));
    // The last visible cell has no successor, so no fetch is issued during it.
    assign w_fetch     = (r_state == S_PREFETCH) | ((r_state == S_ACTIVE) & ~w_last_cell);

    // Pattern for the cell fetched most recently: ROM font row or block graphics.
    always_comb begin
        w_gfx_idx  = {r_char_row[3:2], 1'b0};
        w_gfx_pair = r_code[w_gfx_idx +: 2];
        w_pattern  = 6'd0;
        if (r_code[7]) begin
            if (r_char_row <= 4'd11) begin
                w_pattern = {{3{w_gfx_pair[0]}}, {3{w_gfx_pair[1]}}};
            end
        end else if (r_char_row < 4'd8) begin
            w_pattern = {i_rom_dout, 1'b0};
        end
    end

    // Next-state logic. A line_start aborts any line in progress.
    always_comb begin
        w_next_state = r_state;
        if (w_start) begin
            w_next_state = S_PREFETCH;
        end else begin
            case (r_state)
                S_PREFETCH: if (w_cell_end) w_next_state = S_ACTIVE;
                S_ACTIVE:   if (w_cell_end && w_last_cell) w_next_state = S_IDLE;
                default:    w_next_state = r_state;
            endcase
        end
    end

    // State register. It advances on pixel ticks only.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else if (i_pix_en) begin
            r_state <= w_next_state;
        end
    end

    // Datapath: phase/column counters, fetch pipeline, shifter and strobes.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_phase     <= 3'd0;
            r_sub       <= 1'b0;
            r_wide      <= 1'b0;
            r_text_row  <= 4'd0;
            r_char_row  <= 4'd0;
            r_col       <= 6'd0;
            r_cell      <= 6'd0;
            r_code      <= 8'd0;
            r_shift     <= 6'd0;
            r_de        <= 1'b0;
            r_vram_addr <= 10'd0;
            r_rom_ad    <= 10'd0;
            r_rom_ce    <= 1'b0;
            r_rom_oce   <= 1'b0;
        end else if (i_pix_en) begin
            r_rom_ce  <= 1'b0;
            r_rom_oce <= 1'b0;
            if (w_start) begin
                r_phase    <= 3'd0;
                r_sub      <= 1'b0;
                r_col      <= 6'd0;
                r_cell     <= 6'd0;
                r_shift    <= 6'd0;
                r_de       <= 1'b0;
                r_wide     <= i_mode_wide;
                r_text_row <= i_text_row;
                r_char_row <= i_char_row;
            end else if (r_state != S_IDLE) begin
                if (r_wide) begin
                    r_sub <= ~r_sub;
                end
                if (w_adv) begin
                    r_phase <= w_cell_end ? 3'd0 : r_phase + 3'd1;
                    if (w_fetch) begin
                        case (r_phase)
                            3'd0: begin
                                r_vram_addr <= {r_text_row, r_col};
                                r_col       <= r_col + (r_wide ? 6'd2 : 6'd1);
                            end
                            3'd1: begin
                                r_code   <= i_vram_data;
                                r_rom_ad <= {i_vram_data[6:0], r_char_row[2:0]};
                                r_rom_ce <= 1'b1;
                            end
                            3'd2: r_rom_oce <= 1'b1;
                            default: ;
                        endcase
                    end
                    if (w_cell_end) begin
                        if ((r_state == S_ACTIVE) && w_last_cell) begin
                            r_de    <= 1'b0;
                            r_shift <= 6'd0;
                        end else begin
                            r_de    <= 1'b1;
                            r_shift <= w_pattern;
                            if (r_state == S_ACTIVE) begin
                                r_cell <= r_cell + 6'd1;
                            end
                        end
                    end else begin
                        r_shift <= {r_shift[4:0], 1'b0};
                    end
                end
            end
        end
    end

    // A line_start blanks the output in the same tick it arrives.
    assign w_de        = r_de & ~w_start;
    assign o_de        = w_de;
    assign o_pixel     = w_de & r_shift[5];
    assign o_vram_addr = r_vram_addr;
    assign o_rom_ad    = r_rom_ad;
    assign o_rom_ce    = r_rom_ce;
    assign o_rom_oce   = r_rom_oce;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_trs_text_pixel_gen.sv
// Bench for trs_text_pixel_gen. It includes video RAM and pipelined
// char-ROM models. The expected pixel stream and vram addresses for each
// line are queued when the line starts. They are consumed as the DUT
// produces pixels and ROM strobes.
module tb_trs_text_pixel_gen;

    logic       clk = 1'b0;
    logic       i_reset;
    logic       i_pix_en;
    logic       i_line_start;
    logic [3:0] i_text_row;
    logic [3:0] i_char_row;
    logic       i_mode_wide;
    logic [9:0] o_vram_addr;
    logic [7:0] i_vram_data;
    logic [9:0] o_rom_ad;
    logic       o_rom_ce;
    logic       o_rom_oce;
    logic [4:0] i_rom_dout;
    logic       o_pixel;
    logic       o_de;
    logic [1:0] o_dbg_state;

    logic [7:0] mem [1024];
    logic [9:0] rom_addr_q;

    logic [0:0] exp_q [$];
    logic [9:0] addr_q [$];

    int n_checks = 0;
    int n_errors = 0;
    int tick_cnt, de_cnt, ce_cnt, exp_lat, exp_ce;
    bit seen_de;
    bit gaps;

    trs_text_pixel_gen dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_pix_en     (i_pix_en),
        .i_line_start (i_line_start),
        .i_text_row   (i_text_row),
        .i_char_row   (i_char_row),
        .i_mode_wide  (i_mode_wide),
        .o_vram_addr  (o_vram_addr),
        .i_vram_data  (i_vram_data),
        .o_rom_ad     (o_rom_ad),
        .o_rom_ce     (o_rom_ce),
        .o_rom_oce    (o_rom_oce),
        .i_rom_dout   (i_rom_dout),
        .o_pixel      (o_pixel),
        .o_de         (o_de),
        .o_dbg_state  (o_dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Font: 'A' (0x41) row 0 gives 5'b00100.
    function automatic logic [4:0] font(input logic [6:0] c, input logic [2:0] r);
        logic [4:0] s;
        s = c[4:0] + 5'(r) * 5'd3;
        return s ^ 5'h05;
    endfunction

    // Video RAM: data follows the registered address within one tick.
    assign i_vram_data = mem[o_vram_addr];

    // Char ROM in pipeline read mode: ce latches the address, oce updates the output.
    always @(posedge clk) begin
        if (i_pix_en && o_rom_ce)  rom_addr_q <= o_rom_ad;
        if (i_pix_en && o_rom_oce) i_rom_dout <= font(rom_addr_q[9:3], rom_addr_q[2:0]);
    end

    function automatic logic [5:0] exp_pat(input logic [7:0] c, input logic [3:0] r);
        int  bi;
        logic l, rt;
        if (c[7]) begin
            if (r > 4'd11) return 6'd0;
            bi = int'(r) / 4;
            l  = c[2 * bi];
            rt = c[2 * bi + 1];
            return {l, l, l, rt, rt, rt};
        end
        if (r >= 4'd8) return 6'd0;
        return {font(c[6:0], r[2:0]), 1'b0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard fill for one line.
    task automatic line_expect(input logic [3:0] tr, input logic [3:0] cr, input bit wide);
        int ncells;
        logic [5:0] col;
        logic [9:0] a;
        logic [5:0] p;
        exp_q.delete();
        addr_q.delete();
        ncells = wide ? 32 : 64;
        for (int k = 0; k < ncells; k++) begin
            col = wide ? 6'(2 * k) : 6'(k);
            a = {tr, col};
            addr_q.push_back(a);
            p = exp_pat(mem[a], cr);
            for (int b = 5; b >= 0; b--) begin
                exp_q.push_back(p[b]);
                if (wide) exp_q.push_back(p[b]);
            end
        end
        exp_lat = wide ? 12 : 6;
        exp_ce  = ncells;
    endtask

    task automatic monitor();
        logic [0:0] e;
        logic [9:0] ea;
        if (o_de === 1'b1) begin
            de_cnt++;
            if (!seen_de) begin
                seen_de = 1;
                check("de_latency", tick_cnt, exp_lat);
            end
            if (exp_q.size() == 0) begin
                check("de_extra", de_cnt, 384);
            end else begin
                e = exp_q.pop_front();
                check("pixel", {31'd0, o_pixel}, {31'd0, e});
            end
        end else begin
            check("pixel_blank", {31'd0, o_pixel}, 32'd0);
        end
        if (o_rom_ce === 1'b1) begin
            ce_cnt++;
            if (addr_q.size() == 0) begin
                check("rom_ce_extra", ce_cnt, exp_ce);
            end else begin
                ea = addr_q.pop_front();
                check("vram_addr", {22'd0, o_vram_addr}, {22'd0, ea});
            end
        end
    endtask

    // Driver: one clock, optionally with line_start. Outputs are sampled 1 time unit after the edge.
    task automatic do_tick(input bit ls);
        bit pe;
        i_line_start = ls;
        i_pix_en = (ls || !gaps) ? 1'b1 : 1'($urandom_range(0, 1));
        if (ls) begin
            #1;
            check("de_at_line_start", {31'd0, o_de}, 32'd0);
            check("pixel_at_line_start", {31'd0, o_pixel}, 32'd0);
        end
        @(posedge clk);
        #1;
        pe = i_pix_en;
        i_line_start = 1'b0;
        if (pe) begin
            if (ls) begin
                tick_cnt = 0; de_cnt = 0; ce_cnt = 0; seen_de = 0;
            end else begin
                tick_cnt++;
            end
            monitor();
        end
    endtask

    task automatic start_line(input logic [3:0] tr, input logic [3:0] cr, input bit wide);
        i_text_row  = tr;
        i_char_row  = cr;
        i_mode_wide = wide;
        line_expect(tr, cr, wide);
        do_tick(1'b1);
        // These inputs are sampled at line_start and must be held internally afterwards.
        i_text_row  = 4'($urandom_range(0, 15));
        i_char_row  = 4'($urandom_range(0, 15));
        i_mode_wide = 1'($urandom_range(0, 1));
    endtask

    task automatic finish_line(input string tag);
        bit done;
        done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            do_tick(1'b0);
            if (o_dbg_state == 2'd0) done = 1;
        end
        check({tag, "_complete"}, {31'd0, done}, 32'd1);
        check({tag, "_de_count"}, de_cnt, 384);
        check({tag, "_exp_left"}, exp_q.size(), 0);
        check({tag, "_rom_ce_count"}, ce_cnt, exp_ce);
    endtask

    initial begin
        int bad;
        i_reset = 1'b1; i_pix_en = 1'b1; i_line_start = 1'b0;
        i_text_row = 4'd0; i_char_row = 4'd0; i_mode_wide = 1'b0;
        i_rom_dout = 5'd0; rom_addr_q = 10'd0; gaps = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom_range(0, 255));
        for (int c = 0; c < 64; c++) begin
            mem[{4'd0, 6'(c)}] = 8'h41;
            mem[{4'd5, 6'(c)}] = 8'h95;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_pixel", {31'd0, o_pixel}, 32'd0);
        check("rst_de", {31'd0, o_de}, 32'd0);
        check("rst_vram_addr", {22'd0, o_vram_addr}, 32'd0);
        check("rst_rom_ad", {22'd0, o_rom_ad}, 32'd0);
        check("rst_rom_ce", {31'd0, o_rom_ce}, 32'd0);
        check("rst_rom_oce", {31'd0, o_rom_oce}, 32'd0);
        check("rst_state", {30'd0, o_dbg_state}, 32'd0);
        i_reset = 1'b0;
        repeat (2) do_tick(1'b0);

        // Line of 'A', char_row 0
        start_line(4'd0, 4'd0, 1'b0);
        finish_line("text_A");

        // Block graphics 0x95 on rows 0, 5, 10
        start_line(4'd5, 4'd0, 1'b0);
        finish_line("gfx_r0");
        start_line(4'd5, 4'd5, 1'b0);
        finish_line("gfx_r5");
        start_line(4'd5, 4'd10, 1'b0);
        finish_line("gfx_r10");

        // Wide mode, text_row 3
        start_line(4'd3, 4'd2, 1'b1);
        finish_line("wide");

        // char_row 9: blank text, ROM still strobed per cell
        start_line(4'd0, 4'd9, 1'b0);
        finish_line("blank_row9");

        // Random codes, random char_row, irregular pix_en
        gaps = 1;
        start_line(4'd7, 4'($urandom_range(0, 11)), 1'b0);
        finish_line("random_gaps");
        start_line(4'd9, 4'($urandom_range(0, 11)), 1'b1);
        finish_line("random_wide_gaps");
        gaps = 0;

        // line_start at cell 20 aborts the line
        start_line(4'd1, 4'd3, 1'b0);
        for (int i = 0; i < 400 && de_cnt < 120; i++) do_tick(1'b0);
        check("abort_de_before", {31'd0, o_de}, 32'd1);
        i_text_row = 4'd1; i_char_row = 4'd3; i_mode_wide = 1'b0;
        line_expect(4'd1, 4'd3, 1'b0);
        do_tick(1'b1);
        finish_line("abort_restart");

        // Reset during ACTIVE
        start_line(4'd0, 4'd0, 1'b0);
        repeat (100) do_tick(1'b0);
        i_reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_pixel", {31'd0, o_pixel}, 32'd0);
        check("midrst_de", {31'd0, o_de}, 32'd0);
        check("midrst_rom_ce", {31'd0, o_rom_ce}, 32'd0);
        check("midrst_state", {30'd0, o_dbg_state}, 32'd0);
        i_reset = 1'b0;
        bad = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (o_rom_ce !== 1'b0 || o_rom_oce !== 1'b0 || o_de !== 1'b0) bad++;
        end
        check("quiet_after_reset", bad, 0);

        // Recovery line after reset
        start_line(4'd0, 4'd1, 1'b0);
        finish_line("after_reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
